// File: rtl/paillier_enc_seq.sv
// Paillier encryption sequencer: loads g, m, r, n, then runs g^m and r^n on the
// exponentiator and multiplies the two results to stream out the ciphertext.
module paillier_enc_seq #(
    parameter int K = 128,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enc_start,
    input  logic [K-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         me_start,
    output logic         me_x_valid,
    output logic         me_y_valid,
    output logic [K-1:0] me_x,
    output logic [K-1:0] me_y,
    input  logic [K-1:0] me_result,
    input  logic         me_valid,
    output logic         mm_start,
    output logic         mm_x_valid,
    output logic         mm_y_valid,
    output logic [K-1:0] mm_x,
    output logic [K-1:0] mm_y,
    input  logic [K-1:0] mm_result,
    input  logic         mm_valid,
    output logic [3:0]   state_now,
    output logic [K-1:0] out_data,
    output logic         out_valid,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(4 * N);
    localparam int IW = $clog2(N);

    // state_now: IDLE=0, LOAD=1, ME1_*=2, ME2_*=3, MM_*=4
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ME1_ISSUE, S_ME1_WAIT,
        S_ME2_ISSUE, S_ME2_WAIT, S_MM_ISSUE, S_MM_WAIT
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [IW-1:0]  issue_idx, wr_idx;
    logic [K-1:0]   wr_data;
    logic           wr_a, wr_b, wr_c, wr_d;
    logic           out_we, out_last;

    logic [K-1:0]   a_buf [N];
    logic [K-1:0]   b_buf [N];
    logic [K-1:0]   c_buf [N];
    logic [K-1:0]   d_buf [N];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        in_ready   = 1'b0;
        me_start   = 1'b0;
        me_x_valid = 1'b0;
        me_y_valid = 1'b0;
        me_x       = '0;
        me_y       = '0;
        mm_start   = 1'b0;
        mm_x_valid = 1'b0;
        mm_y_valid = 1'b0;
        mm_x       = '0;
        mm_y       = '0;
        state_now  = 4'd0;
        busy       = 1'b0;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        wr_c       = 1'b0;
        wr_d       = 1'b0;
        wr_idx     = '0;
        wr_data    = in_data;
        out_we     = 1'b0;
        out_last   = 1'b0;
        // cnt==0 is the start cycle, so streamed word i goes out at cnt==i+1
        issue_idx  = IW'(cnt - CW'(1));
        case (state)
            S_IDLE: begin
                if (enc_start) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                state_now = 4'd1;
                busy      = 1'b1;
                in_ready  = 1'b1;
                if (in_valid) begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt < CW'(N)) begin
                        wr_a   = 1'b1;
                        wr_idx = IW'(cnt);
                    end else if (cnt < CW'(2 * N)) begin
                        wr_b   = 1'b1;
                        wr_idx = IW'(cnt - CW'(N));
                    end else if (cnt < CW'(3 * N)) begin
                        wr_c   = 1'b1;
                        wr_idx = IW'(cnt - CW'(2 * N));
                    end else begin
                        wr_d   = 1'b1;
                        wr_idx = IW'(cnt - CW'(3 * N));
                    end
                    if (cnt == CW'(4 * N - 1)) begin
                        state_nxt = S_ME1_ISSUE;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_ME1_ISSUE, S_ME2_ISSUE: begin
                state_now = (state == S_ME1_ISSUE) ? 4'd2 : 4'd3;
                busy      = 1'b1;
                cnt_nxt   = cnt + CW'(1);
                if (cnt == '0) begin
                    me_start = 1'b1;
                end else begin
                    me_x_valid = 1'b1;
                    me_y_valid = 1'b1;
                    me_x = (state == S_ME1_ISSUE) ? a_buf[issue_idx] : c_buf[issue_idx];
                    me_y = (state == S_ME1_ISSUE) ? b_buf[issue_idx] : d_buf[issue_idx];
                end
                if (cnt == CW'(N)) begin
                    state_nxt = (state == S_ME1_ISSUE) ? S_ME1_WAIT : S_ME2_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_ME1_WAIT, S_ME2_WAIT: begin
                state_now = (state == S_ME1_WAIT) ? 4'd2 : 4'd3;
                busy      = 1'b1;
                if (me_valid) begin
                    wr_a    = (state == S_ME1_WAIT);
                    wr_b    = (state == S_ME2_WAIT);
                    wr_idx  = IW'(cnt);
                    wr_data = me_result;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state_nxt = (state == S_ME1_WAIT) ? S_ME2_ISSUE : S_MM_ISSUE;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_MM_ISSUE: begin
                state_now = 4'd4;
                busy      = 1'b1;
                cnt_nxt   = cnt + CW'(1);
                if (cnt == '0) begin
                    mm_start = 1'b1;
                end else begin
                    mm_x_valid = 1'b1;
                    mm_y_valid = 1'b1;
                    mm_x       = a_buf[issue_idx];
                    mm_y       = b_buf[issue_idx];
                end
                if (cnt == CW'(N)) begin
                    state_nxt = S_MM_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_MM_WAIT: begin
                state_now = 4'd4;
                busy      = 1'b1;
                if (mm_valid) begin
                    out_we  = 1'b1;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        out_last  = 1'b1;
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_valid <= out_we;
            done      <= out_last;
            out_data  <= out_we ? mm_result : '0;
        end
    end

    // Operand buffers carry no reset; every phase reloads before reading.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_a) a_buf[wr_idx] <= wr_data;
            if (wr_b) b_buf[wr_idx] <= wr_data;
            if (wr_c) c_buf[wr_idx] <= wr_data;
            if (wr_d) d_buf[wr_idx] <= wr_data;
        end
    end
endmodule

// File: tb/tb_paillier_enc_seq.sv
// Bench for paillier_enc_seq: behavioural exponentiator/multiplier stubs with
// adjustable latency, ciphertext compared against c = g^m * r^n mod n^2.
module tb_paillier_enc_seq;
    localparam int K = 16;
    localparam int N = 4;
    localparam int W = K * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enc_start = 1'b0;
    logic [K-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         me_start, me_x_valid, me_y_valid, me_valid;
    logic [K-1:0] me_x, me_y, me_result;
    logic         mm_start, mm_x_valid, mm_y_valid, mm_valid;
    logic [K-1:0] mm_x, mm_y, mm_result;
    logic [3:0]   state_now;
    logic [K-1:0] out_data;
    logic         out_valid, busy, done;

    logic         me_v_stub = 1'b0, mm_v_stub = 1'b0;
    logic         me_v_inj = 1'b0, mm_v_inj = 1'b0;
    logic [K-1:0] me_r_stub = '0, mm_r_stub = '0, inj_data = '0;

    assign me_valid  = me_v_stub | me_v_inj;
    assign me_result = me_v_inj ? inj_data : me_r_stub;
    assign mm_valid  = mm_v_stub | mm_v_inj;
    assign mm_result = mm_v_inj ? inj_data : mm_r_stub;

    int n_checks = 0;
    int n_fail = 0;
    longint unsigned stub_n2 = 64'd32041;
    int lat = 2;
    int gap = 0;

    always #5 clk = ~clk;

    paillier_enc_seq #(.K(K), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .enc_start(enc_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .me_start(me_start), .me_x_valid(me_x_valid), .me_y_valid(me_y_valid),
        .me_x(me_x), .me_y(me_y), .me_result(me_result), .me_valid(me_valid),
        .mm_start(mm_start), .mm_x_valid(mm_x_valid), .mm_y_valid(mm_y_valid),
        .mm_x(mm_x), .mm_y(mm_y), .mm_result(mm_result), .mm_valid(mm_valid),
        .state_now(state_now), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    function automatic longint unsigned modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                               input longint unsigned md);
        longint unsigned acc = 1 % md;
        longint unsigned x = b % md;
        for (int i = 0; i < W; i++) begin
            if (e[i]) acc = (acc * x) % md;
            x = (x * x) % md;
        end
        return acc;
    endfunction

    function automatic longint unsigned enc_ref(input logic [W-1:0] g, input logic [W-1:0] m,
                                                input logic [W-1:0] r, input logic [W-1:0] n);
        longint unsigned n2 = n * n;
        return (modexp(g, m, n2) * modexp(r, n, n2)) % n2;
    endfunction

    // Exponentiator stub: gathers N word pairs after me_start, answers later.
    int me_cap = N, me_emit = 0, me_wait = 0;
    bit me_pend = 1'b0;
    logic [W-1:0] me_xa = '0, me_ya = '0, me_res = '0;
    always @(negedge clk) begin
        me_v_stub = 1'b0;
        if (me_pend) begin
            if (me_wait > 0) me_wait--;
            else begin
                me_v_stub = 1'b1;
                me_r_stub = me_res[me_emit*K +: K];
                me_emit++;
                me_wait = gap;
                if (me_emit == N) me_pend = 1'b0;
            end
        end
        if (me_start) begin
            me_cap = 0; me_xa = '0; me_ya = '0;
        end
        if (me_x_valid && me_cap < N) begin
            me_xa[me_cap*K +: K] = me_x;
            me_ya[me_cap*K +: K] = me_y;
            me_cap++;
            if (me_cap == N) begin
                me_res = W'(modexp(me_xa, me_ya, stub_n2));
                me_pend = 1'b1; me_emit = 0; me_wait = lat - 1;
            end
        end
    end

    int mm_cap = N, mm_emit = 0, mm_wait = 0;
    bit mm_pend = 1'b0;
    logic [W-1:0] mm_xa = '0, mm_ya = '0, mm_res = '0;
    always @(negedge clk) begin
        mm_v_stub = 1'b0;
        if (mm_pend) begin
            if (mm_wait > 0) mm_wait--;
            else begin
                mm_v_stub = 1'b1;
                mm_r_stub = mm_res[mm_emit*K +: K];
                mm_emit++;
                mm_wait = gap;
                if (mm_emit == N) mm_pend = 1'b0;
            end
        end
        if (mm_start) begin
            mm_cap = 0; mm_xa = '0; mm_ya = '0;
        end
        if (mm_x_valid && mm_cap < N) begin
            mm_xa[mm_cap*K +: K] = mm_x;
            mm_ya[mm_cap*K +: K] = mm_y;
            mm_cap++;
            if (mm_cap == N) begin
                mm_res = W'(((mm_xa % stub_n2) * (mm_ya % stub_n2)) % stub_n2);
                mm_pend = 1'b1; mm_emit = 0; mm_wait = lat - 1;
            end
        end
    end

    logic [K-1:0] out_q [$];
    logic [3:0]   trace [$];
    int done_cnt = 0;
    int viol = 0;
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (out_valid) out_q.push_back(out_data);
        if (done) begin
            done_cnt++;
            if (!out_valid || prev_done) viol++;
        end
        prev_done = done;
        if (me_start && mm_start) viol++;
        if ((mm_start || mm_x_valid || mm_y_valid) && state_now != 4'd4) viol++;
        if (busy !== (state_now != 4'd0)) viol++;
        if (trace.size() == 0 || trace[trace.size()-1] != state_now) trace.push_back(state_now);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctrl"}, 128'({in_ready, me_start, me_x_valid, me_y_valid, mm_start,
              mm_x_valid, mm_y_valid, out_valid, busy, done, state_now}), 128'(0));
        check({tag, "_data"}, 128'({me_x, me_y, mm_x, mm_y, out_data}), 128'(0));
    endtask

    logic [W-1:0] cur_g, cur_m, cur_r, cur_n;
    int job_d0 = 0;

    task automatic rand_ops(output logic [W-1:0] g, output logic [W-1:0] m,
                            output logic [W-1:0] r, output logic [W-1:0] n);
        g = {$urandom, $urandom};
        m = {$urandom, $urandom};
        r = {$urandom, $urandom};
        n = W'(129 + 2 * $urandom_range(0, 63));
    endtask

    task automatic begin_job(input logic [W-1:0] g, input logic [W-1:0] m,
                             input logic [W-1:0] r, input logic [W-1:0] n, input bit stall);
        logic [W-1:0] ops [4];
        int idx = 0;
        int b = 0;
        bit acc;
        bit ph = 1'b0;
        cur_g = g; cur_m = m; cur_r = r; cur_n = n;
        stub_n2 = n * n;
        job_d0 = done_cnt;
        ops[0] = g; ops[1] = m; ops[2] = r; ops[3] = n;
        out_q.delete();
        trace.delete();
        tick();
        enc_start = 1'b1;
        tick();
        enc_start = 1'b0;
        while (idx < 4 * N && b < 200) begin
            if (stall && ph) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                in_data = ops[idx / N][(idx % N)*K +: K];
            end
            acc = in_valid && in_ready;
            ph = !ph;
            tick();
            b++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("load_count", 128'(idx), 128'(4 * N));
    endtask

    task automatic finish_job(input string tag);
        logic [W-1:0] cw;
        logic [3:0] exp_tr [6];
        int b = 0;
        exp_tr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        cw = W'(enc_ref(cur_g, cur_m, cur_r, cur_n));
        while (done_cnt == job_d0 && b < 500) begin
            tick();
            b++;
        end
        check({tag, "_done"}, 128'(done_cnt), 128'(job_d0 + 1));
        check({tag, "_nwords"}, 128'(out_q.size()), 128'(N));
        for (int i = 0; i < N; i++)
            check($sformatf("%s_word%0d", tag, i),
                  128'((i < out_q.size()) ? out_q[i] : {K{1'bx}}), 128'(cw[i*K +: K]));
        check({tag, "_trace_len"}, 128'(trace.size()), 128'(6));
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_trace%0d", tag, i),
                  128'((i < trace.size()) ? trace[i] : 4'hF), 128'(exp_tr[i]));
        check({tag, "_protocol"}, 128'(viol), 128'(0));
    endtask

    task automatic poll_phase(input string tag, input logic [3:0] code, input logic stream);
        int b = 0;
        while (!(state_now == code && me_x_valid == stream && !me_start) && b < 300) begin
            tick();
            b++;
        end
        check(tag, 128'({state_now, me_x_valid, me_start}), 128'({code, stream, 1'b0}));
    endtask

    initial begin
        logic [W-1:0] g, m, r, n;
        int b;

        rst_n = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Reference case: g = n+1, m = 5, r = 7, n = 0xB3
        lat = 2; gap = 0;
        begin_job(W'(64'hB4), W'(5), W'(7), W'(64'hB3), 1'b0);
        finish_job("basic");

        // Stalled load, then exact issue timing of the first exponentiation
        lat = 1;
        rand_ops(g, m, r, n);
        begin_job(g, m, r, n, 1'b1);
        in_valid = 1'b1;
        in_data = 16'hBEEF;
        check("stall_ready_low", 128'(in_ready), 128'(0));
        check("stall_me_start", 128'(me_start), 128'(1));
        for (int i = 0; i < N; i++) begin
            tick();
            check($sformatf("issue_valid%0d", i), 128'({me_start, me_x_valid, me_y_valid}), 128'(3'b011));
            check($sformatf("issue_x%0d", i), 128'(me_x), 128'(g[i*K +: K]));
            check($sformatf("issue_y%0d", i), 128'(me_y), 128'(m[i*K +: K]));
        end
        tick();
        check("issue_end", 128'({me_start, me_x_valid, me_y_valid, me_x, me_y}), 128'(0));
        in_valid = 1'b0;
        finish_job("stall");

        // Stray strobes and a stray start request must leave the job untouched
        lat = 6;
        rand_ops(g, m, r, n);
        begin_job(g, m, r, n, 1'b0);
        poll_phase("spur_me1_wait", 4'd2, 1'b0);
        inj_data = 16'hDEAD;
        mm_v_inj = 1'b1;
        tick();
        mm_v_inj = 1'b0;
        poll_phase("spur_me2_issue", 4'd3, 1'b1);
        inj_data = 16'h5A5A;
        me_v_inj = 1'b1;
        tick();
        me_v_inj = 1'b0;
        poll_phase("spur_me2_wait", 4'd3, 1'b0);
        enc_start = 1'b1;
        tick();
        enc_start = 1'b0;
        finish_job("spurious");

        // Reset after two ciphertext words; remaining results arrive into IDLE
        lat = 2; gap = 3;
        rand_ops(g, m, r, n);
        begin_job(g, m, r, n, 1'b0);
        b = 0;
        while (out_q.size() < 2 && b < 600) begin
            tick();
            b++;
        end
        check("rst_two_words", 128'(out_q.size()), 128'(2));
        rst_n = 1'b0;
        tick();
        check_quiet("rst_mid");
        rst_n = 1'b1;
        repeat (20) tick();
        check("rst_no_late_out", 128'(out_q.size()), 128'(2));
        check("rst_no_done", 128'(done_cnt), 128'(job_d0));
        gap = 0;

        // Back-to-back: the second start lands on the cycle after done
        rand_ops(g, m, r, n);
        begin_job(g, m, r, n, 1'b0);
        finish_job("b2b_first");
        rand_ops(g, m, r, n);
        begin_job(g, m, r, n, 1'b0);
        finish_job("b2b_second");

        for (int j = 0; j < 3; j++) begin
            lat = $urandom_range(1, 4);
            gap = $urandom_range(0, 2);
            rand_ops(g, m, r, n);
            begin_job(g, m, r, n, 1'($urandom_range(0, 1)));
            finish_job($sformatf("rand%0d", j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/paillier_enc_seq.md
PAILLIER_ENC_SEQ -- requirements
Module: paillier_enc_seq

Interface
REQ-001 Parameter K, default 128, operand word width in bits.
REQ-002 Parameter N, default 32, words per operand, low word first; N >= 2.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 enc_start  input  1  one-cycle request to start an encryption.
REQ-006 in_data  input  K  operand word stream.
REQ-007 in_valid / in_ready  input / output  1 / 1  operand stream handshake.
REQ-008 me_start, me_x_valid, me_y_valid  output  1 each  modular-exponentiation request and word strobes.
REQ-009 me_x, me_y  output  K each  base word and exponent word.
REQ-010 me_result / me_valid  input  K / 1  exponentiation result word and strobe.
REQ-011 mm_start, mm_x_valid, mm_y_valid  output  1 each  modular-multiplication request and word strobes.
REQ-012 mm_x, mm_y  output  K each  multiplicand words.
REQ-013 mm_result / mm_valid  input  K / 1  multiplication result word and strobe.
REQ-014 state_now  output  4  encoding of the current phase, for the Montgomery top.
REQ-015 out_data / out_valid  output  K / 1  ciphertext word stream; no backpressure.
REQ-016 busy / done  output  1 / 1  busy is high outside IDLE; done is a one-cycle pulse.

Function
REQ-017 The block SHALL compute c = (g^m mod n^2)·(r^n mod n^2) mod n^2 by sequencing ME1, ME2, then MM.
REQ-018 Storage SHALL be four N×K buffers: A, B, C, D.
REQ-019 The FSM states and state_now codes SHALL be: IDLE=0, LOAD=1, ME1_ISSUE/ME1_WAIT=2, ME2_ISSUE/ME2_WAIT=3, MM_ISSUE/MM_WAIT=4.
REQ-020 IDLE: enc_start SHALL move the FSM to LOAD on the next cycle; enc_start SHALL be ignored in all other states.
REQ-021 LOAD: in_ready SHALL be 1 and each in_valid&in_ready cycle SHALL store one word.
REQ-022 LOAD word order SHALL be: words 0..N-1 to A (g), N..2N-1 to B (m), 2N..3N-1 to C (r), 3N..4N-1 to D (n).
REQ-023 After the 4N-th accepted word, in_ready SHALL fall the next cycle and the FSM SHALL enter ME1_ISSUE.
REQ-024 ISSUE timing: start SHALL pulse for one cycle at cycle T; during T+1..T+N, x_valid and y_valid SHALL both be 1 with word i on cycle T+1+i; then the FSM SHALL enter WAIT.
REQ-025 ME1 SHALL use x=A and y=B.
REQ-026 ME1_WAIT: the i-th me_valid SHALL write me_result into A[i]; after the N-th, the FSM SHALL go to ME2_ISSUE.
REQ-027 ME2 SHALL use x=C and y=D.
REQ-028 ME2_WAIT: results SHALL be written into B[i]; after the N-th, the FSM SHALL go to MM_ISSUE.
REQ-029 MM SHALL use x=A and y=B.
REQ-030 MM_WAIT: each mm_valid SHALL drive out_data<=mm_result and out_valid=1 one cycle later (registered).
REQ-031 After the N-th MM word, done SHALL pulse with the last out_valid and the FSM SHALL return to IDLE.
REQ-032 Result strobes outside the matching WAIT state SHALL be ignored and SHALL write no buffer.
REQ-033 Result strobes arriving during ISSUE streaming SHALL be ignored.
REQ-034 me_start and mm_start SHALL never be high in the same cycle.
REQ-035 No mm_* strobe SHALL assert before the ME2 result count reaches N.
REQ-036 Word counters SHALL be clog2(4N) bits and SHALL reset to 0 at each phase entry; no wrap SHALL be observable.
REQ-037 in_valid while in_ready=0 SHALL be ignored.
REQ-038 When not streaming, me_x, me_y, mm_x and mm_y SHALL drive 0.

Reset
REQ-039 rst_n=0 at any clock edge SHALL force IDLE and clear all counters.
REQ-040 During reset, all outputs SHALL be 0: in_ready, every start and valid strobe, out_valid, busy, done, state_now=0, and all data outputs.
REQ-041 Buffer contents SHALL be undefined after reset; nothing SHALL be read from a buffer before it is reloaded.
REQ-042 Reset mid-operation SHALL abandon the job; results arriving after reset SHALL be ignored.

Verification (N=4, K=16, behavioural ME/MM stub with configurable latency)
REQ-043 Full encryption: load g=n+1, m=5, r=7, n=0x00B3 (n^2 in stub) -> out_data words equal the reference model, done pulses once, and state_now follows 0,1,2,3,4,0.
REQ-044 Stall load: in_valid low every other cycle -> exactly 16 words accepted, in_ready low after the 16th, ME1 me_start occurs 1 cycle later.
REQ-045 ISSUE timing: me_start at T -> x/y_valid high for cycles T+1..T+4 carrying A[0..3], then low.
REQ-046 Spurious strobes: mm_valid pulse during ME1_WAIT, and enc_start during ME2_WAIT -> no buffer change, no restart, and the final result is unchanged.
REQ-047 Reset in MM_WAIT after 2 result words -> outputs 0 the next cycle and state_now=0; later mm_valid pulses produce no out_valid.
REQ-048 Back-to-back jobs: enc_start on the cycle after done -> second job is accepted and produces correct output.
